// File: rtl/sc_datapath_pkg.sv
// rtl/sc_datapath_pkg.sv - shared widths and selector encodings for the SC datapath and its controller
package sc_datapath_pkg;

    localparam int SC_BUS_WIDTH       = 8;
    localparam int SC_DECODER_WIDTH   = 3;
    localparam int SC_MUX_WIDTH       = 3;
    localparam int SC_ALU_WIDTH       = 4;
    localparam int SC_SHIFTMODE_WIDTH = 2;

    typedef enum logic [3:0] {
        ALU_PASS = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_NOT  = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_ADD  = 4'b1000,
        ALU_SUB  = 4'b1001,
        ALU_INC  = 4'b1010,
        ALU_DEC  = 4'b1011
    } alu_op_e;

    typedef enum logic [2:0] {
        SRC_GEN0  = 3'b000,
        SRC_GEN1  = 3'b001,
        SRC_GEN2  = 3'b010,
        SRC_GEN3  = 3'b011,
        SRC_FIX0  = 3'b100,
        SRC_FIX1  = 3'b101,
        SRC_ZERO0 = 3'b110,
        SRC_ZERO1 = 3'b111
    } mux_src_e;

    typedef enum logic [2:0] {
        DEC_GEN0 = 3'b000,
        DEC_GEN1 = 3'b001,
        DEC_GEN2 = 3'b010,
        DEC_GEN3 = 3'b011,
        DEC_NONE = 3'b100
    } decoder_sel_e;

    typedef enum logic [1:0] {
        SHIFT_HOLD  = 2'b00,
        SHIFT_LEFT  = 2'b01,
        SHIFT_RIGHT = 2'b10,
        SHIFT_HOLD2 = 2'b11
    } shift_mode_e;

endpackage

// File: rtl/sc_alu.sv
// rtl/sc_alu.sv - combinational ALU with carry/overflow/negative/zero flags (active-high)
module sc_alu
    import sc_datapath_pkg::*;
#(
    parameter int DATAWIDTH_BUS           = SC_BUS_WIDTH,
    parameter int DATAWIDTH_ALU_SELECTION = SC_ALU_WIDTH
) (
    input  logic [DATAWIDTH_BUS-1:0]           a,
    input  logic [DATAWIDTH_BUS-1:0]           b,
    input  logic [DATAWIDTH_ALU_SELECTION-1:0] sel,
    output logic [DATAWIDTH_BUS-1:0]           result,
    output logic                               overflow,
    output logic                               carry,
    output logic                               negative,
    output logic                               zero
);

    localparam int MSB = DATAWIDTH_BUS - 1;

    logic [DATAWIDTH_BUS:0]   wide;
    logic [DATAWIDTH_BUS-1:0] operand_b;
    logic                     subtract;
    logic                     arith;

    always_comb begin
        operand_b = b;
        subtract  = 1'b0;
        arith     = 1'b0;
        result    = a;
        overflow  = 1'b0;
        carry     = 1'b0;
        case (sel)
            ALU_OR:  result = a | b;
            ALU_AND: result = a & b;
            ALU_NOT: result = ~a;
            ALU_XOR: result = a ^ b;
            ALU_ADD: arith = 1'b1;
            ALU_SUB: begin arith = 1'b1; subtract = 1'b1; end
            ALU_INC: begin arith = 1'b1; operand_b = DATAWIDTH_BUS'(1); end
            ALU_DEC: begin arith = 1'b1; subtract = 1'b1; operand_b = DATAWIDTH_BUS'(1); end
            default: result = a;
        endcase
        // Ninth bit carries out on add and reads as borrow on subtract.
        wide = subtract ? ({1'b0, a} - {1'b0, operand_b}) : ({1'b0, a} + {1'b0, operand_b});
        if (arith) begin
            result = wide[DATAWIDTH_BUS-1:0];
            carry  = wide[DATAWIDTH_BUS];
            if (subtract)
                overflow = (a[MSB] != operand_b[MSB]) && (wide[MSB] != a[MSB]);
            else
                overflow = (a[MSB] == operand_b[MSB]) && (wide[MSB] != a[MSB]);
        end
        negative = result[MSB];
        zero     = (result == '0);
    end

endmodule

// File: rtl/sc_datapath.sv
// rtl/sc_datapath.sv - register file, bus muxes and shifter around sc_alu for the SC state machine
module sc_datapath
    import sc_datapath_pkg::*;
#(
    parameter int DATAWIDTH_BUS                                = SC_BUS_WIDTH,
    parameter int DATAWIDTH_DECODER_SELECTION                  = SC_DECODER_WIDTH,
    parameter int DATAWIDTH_MUX_SELECTION                      = SC_MUX_WIDTH,
    parameter int DATAWIDTH_ALU_SELECTION                      = SC_ALU_WIDTH,
    parameter int DATAWIDTH_REGSHIFTER_SELECTION               = SC_SHIFTMODE_WIDTH,
    parameter logic [DATAWIDTH_BUS-1:0] REGFIX0_VALUE          = 8'd1,
    parameter logic [DATAWIDTH_BUS-1:0] REGFIX1_VALUE          = 8'd5
) (
    input  logic                                      SC_STATEMACHINE_CLOCK_50,
    input  logic                                      SC_STATEMACHINE_RESET_InHigh,
    input  logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_DATAPATH_decoderclearselection_InBUS,
    input  logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_DATAPATH_decoderloadselection_InBUS,
    input  logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_DATAPATH_muxselectionBUSA_InBUS,
    input  logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_DATAPATH_muxselectionBUSB_InBUS,
    input  logic [DATAWIDTH_ALU_SELECTION-1:0]        SC_DATAPATH_aluselection_InBUS,
    input  logic                                      SC_DATAPATH_regSHIFTERclear_InLow,
    input  logic                                      SC_DATAPATH_regSHIFTERload_InLow,
    input  logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_DATAPATH_regSHIFTERshiftselection_InLow,
    output logic                                      SC_DATAPATH_overflow_OutLow,
    output logic                                      SC_DATAPATH_carry_OutLow,
    output logic                                      SC_DATAPATH_negative_OutLow,
    output logic                                      SC_DATAPATH_zero_OutLow,
    output logic [DATAWIDTH_BUS-1:0]                  SC_DATAPATH_regGEN3_OutBUS,
    output logic [DATAWIDTH_BUS-1:0]                  SC_DATAPATH_regSHIFTER_OutBUS
);

    logic [DATAWIDTH_BUS-1:0] reg_gen [4];
    logic [DATAWIDTH_BUS-1:0] reg_shifter;
    logic [DATAWIDTH_BUS-1:0] bus_a;
    logic [DATAWIDTH_BUS-1:0] bus_b;
    logic [DATAWIDTH_BUS-1:0] alu_result;
    logic                     alu_overflow;
    logic                     alu_carry;
    logic                     alu_negative;
    logic                     alu_zero;

    function automatic logic [DATAWIDTH_BUS-1:0] bus_source(
        input logic [DATAWIDTH_MUX_SELECTION-1:0] sel,
        input logic [DATAWIDTH_BUS-1:0]           gen0,
        input logic [DATAWIDTH_BUS-1:0]           gen1,
        input logic [DATAWIDTH_BUS-1:0]           gen2,
        input logic [DATAWIDTH_BUS-1:0]           gen3
    );
        case (sel)
            SRC_GEN0: return gen0;
            SRC_GEN1: return gen1;
            SRC_GEN2: return gen2;
            SRC_GEN3: return gen3;
            SRC_FIX0: return REGFIX0_VALUE;
            SRC_FIX1: return REGFIX1_VALUE;
            default:  return '0;
        endcase
    endfunction

    always_comb begin
        bus_a = bus_source(SC_DATAPATH_muxselectionBUSA_InBUS,
                           reg_gen[0], reg_gen[1], reg_gen[2], reg_gen[3]);
        bus_b = bus_source(SC_DATAPATH_muxselectionBUSB_InBUS,
                           reg_gen[0], reg_gen[1], reg_gen[2], reg_gen[3]);
    end

    sc_alu #(
        .DATAWIDTH_BUS           (DATAWIDTH_BUS),
        .DATAWIDTH_ALU_SELECTION (DATAWIDTH_ALU_SELECTION)
    ) u_alu (
        .a        (bus_a),
        .b        (bus_b),
        .sel      (SC_DATAPATH_aluselection_InBUS),
        .result   (alu_result),
        .overflow (alu_overflow),
        .carry    (alu_carry),
        .negative (alu_negative),
        .zero     (alu_zero)
    );

    // Clear beats load when both decoders name the same register.
    always_ff @(posedge SC_STATEMACHINE_CLOCK_50 or posedge SC_STATEMACHINE_RESET_InHigh) begin
        if (SC_STATEMACHINE_RESET_InHigh) begin
            for (int i = 0; i < 4; i++)
                reg_gen[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (SC_DATAPATH_decoderclearselection_InBUS == DATAWIDTH_DECODER_SELECTION'(i))
                    reg_gen[i] <= '0;
                else if (SC_DATAPATH_decoderloadselection_InBUS == DATAWIDTH_DECODER_SELECTION'(i))
                    reg_gen[i] <= reg_shifter;
            end
        end
    end

    always_ff @(posedge SC_STATEMACHINE_CLOCK_50 or posedge SC_STATEMACHINE_RESET_InHigh) begin
        if (SC_STATEMACHINE_RESET_InHigh)
            reg_shifter <= '0;
        else if (!SC_DATAPATH_regSHIFTERclear_InLow)
            reg_shifter <= '0;
        else if (!SC_DATAPATH_regSHIFTERload_InLow)
            reg_shifter <= alu_result;
        else if (SC_DATAPATH_regSHIFTERshiftselection_InLow == SHIFT_LEFT)
            reg_shifter <= {reg_shifter[DATAWIDTH_BUS-2:0], 1'b0};
        else if (SC_DATAPATH_regSHIFTERshiftselection_InLow == SHIFT_RIGHT)
            reg_shifter <= {1'b0, reg_shifter[DATAWIDTH_BUS-1:1]};
    end

    assign SC_DATAPATH_overflow_OutLow   = ~alu_overflow;
    assign SC_DATAPATH_carry_OutLow      = ~alu_carry;
    assign SC_DATAPATH_negative_OutLow   = ~alu_negative;
    assign SC_DATAPATH_zero_OutLow       = ~alu_zero;
    assign SC_DATAPATH_regGEN3_OutBUS    = reg_gen[3];
    assign SC_DATAPATH_regSHIFTER_OutBUS = reg_shifter;

endmodule

// File: doc/sc_datapath.md
SC_DATAPATH -- requirements
Module: sc_datapath

Interface
REQ-001 The block SHALL have parameter DATAWIDTH_BUS, default 8, meaning the width of all registers, buses and the ALU.
REQ-002 The block SHALL have parameter DATAWIDTH_DECODER_SELECTION, default 3, meaning the register clear/load selector width.
REQ-003 The block SHALL have parameter DATAWIDTH_MUX_SELECTION, default 3, meaning the BUSA/BUSB source selector width.
REQ-004 The block SHALL have parameter DATAWIDTH_ALU_SELECTION, default 4, meaning the ALU opcode width.
REQ-005 The block SHALL have parameter DATAWIDTH_REGSHIFTER_SELECTION, default 2, meaning the shifter mode width.
REQ-006 The block SHALL have parameter REGFIX0_VALUE, default 8'd1, meaning the constant held in RegFIX0.
REQ-007 The block SHALL have parameter REGFIX1_VALUE, default 8'd5, meaning the constant held in RegFIX1.
REQ-008 SC_STATEMACHINE_CLOCK_50  in  1  clock; all state SHALL update on its rising edge.
REQ-009 SC_STATEMACHINE_RESET_InHigh  in  1  reset, asynchronous, active-high.
REQ-010 SC_DATAPATH_decoderclearselection_InBUS  in  3  000-011 clears RegGEN0-3; 1xx selects none.
REQ-011 SC_DATAPATH_decoderloadselection_InBUS  in  3  000-011 loads RegGEN0-3 from shifter; 1xx selects none.
REQ-012 SC_DATAPATH_muxselectionBUSA_InBUS / _muxselectionBUSB_InBUS  in  3 each  000-011 RegGEN0-3, 100 RegFIX0, 101 RegFIX1, 110/111 drive zero.
REQ-013 SC_DATAPATH_aluselection_InBUS  in  4  0000 A; 0001 OR; 0010 AND; 0011 NOT A; 0100 XOR; 1000 ADD; 1001 SUB; 1010 INC; 1011 DEC; all other codes pass A.
REQ-014 SC_DATAPATH_regSHIFTERclear_InLow / _regSHIFTERload_InLow  in  1 each  shifter clear / load, active-low.
REQ-015 SC_DATAPATH_regSHIFTERshiftselection_InLow  in  2  01 shift left, 10 shift right, 00/11 hold.
REQ-016 SC_DATAPATH_overflow_OutLow, _carry_OutLow, _negative_OutLow, _zero_OutLow  out  1 each  ALU flags, active-low (0 = flag true).
REQ-017 SC_DATAPATH_regGEN3_OutBUS and SC_DATAPATH_regSHIFTER_OutBUS  out  8 each  live RegGEN3 and shifter contents for display.

Function
REQ-018 BUSA, BUSB, the ALU result and all four flags SHALL be purely combinational from the current selectors and register contents, so the controller can branch on them in the same cycle (zero-cycle latency).
REQ-019 Arithmetic SHALL be performed on DATAWIDTH_BUS+1 bits: ADD A+B, SUB A-B, INC A+1, DEC A-1; result wraps modulo 2^8 (DEC of 0 gives 8'hFF, INC of 8'hFF gives 0).
REQ-020 The carry flag SHALL be bit 8 of the arithmetic result (carry for ADD/INC, borrow for SUB/DEC) and 0 for logic/pass ops.
REQ-021 The overflow flag SHALL be two's-complement signed overflow for arithmetic ops and 0 otherwise.
REQ-022 The negative flag SHALL be result bit 7 and the zero flag SHALL be (result == 0) for every opcode.
REQ-023 The shifter SHALL capture in priority order on the clock edge: clear (to 0) > load (ALU result) > shift left (LSB filled with 0) > shift right (MSB filled with 0) > hold.
REQ-024 A selected RegGENn SHALL capture shifter contents on the clock edge when its load code is presented; a selected clear SHALL set it to 0, and clear SHALL win when both select the same register.
REQ-025 Clear of one register and load of a different register in the same cycle SHALL both take effect.
REQ-026 RegFIX0 and RegFIX1 SHALL be read-only constants and never written.
REQ-027 A three-cycle controller micro-sequence (select/ALU; shifter load; register load) SHALL complete one register transfer, the shifter-to-register path reading pre-edge shifter contents.

Reset
REQ-028 Reset assertion SHALL asynchronously set RegGEN0-3 and the shifter to 0; all outputs then follow combinationally (with all-ones selectors: flags overflow/carry/negative_OutLow = 1, zero_OutLow = 0; both data outputs = 0).
REQ-029 Reset asserted mid-sequence SHALL abort any pending transfer; no register retains a partially completed value.

Structure
REQ-030 A shared package sc_datapath_pkg SHALL hold the ALU opcode, mux source, decoder and shift-mode constants and the bus widths, shared with the controller.
REQ-031 The ALU and flag generation SHALL be a sub-module named sc_alu; the register file, muxes and shifter remain in sc_datapath.

Verification
REQ-032 Reset with all selectors 1s -> all registers 0, zero_OutLow=0, other flags 1.
REQ-033 MOV sequence BUSA=101, ALU=0000; shifter load; load code 010 -> RegGEN2 = 8'd5 after third edge.
REQ-034 RegGEN2=1, BUSA=010, ALU=1011 -> zero_OutLow=0 same cycle; RegGEN2=5 -> zero_OutLow=1; RegGEN2=0 -> result 8'hFF, carry_OutLow=0, negative_OutLow=0.
REQ-035 ADD 8'hFF+8'h01 -> result 0, carry_OutLow=0, zero_OutLow=0; ADD 8'h7F+8'h01 -> 8'h80, overflow_OutLow=0, negative_OutLow=0.
REQ-036 Shifter load 8'h81, shift 01 -> 8'h02, shift 10 -> 8'h01; clear and load together -> 8'h00.
REQ-037 Drive with the Fibonacci-loop controller, REGFIX0=1, REGFIX1=5 -> controller reaches its end state with RegGEN2=0 and regGEN3_OutBUS = 8'd5.
